// File: rtl/lut_func_engine.sv
// -----------------------------------------------------------------------------
// lut_func_engine
//
// Programmable N_IN-input Boolean function. The truth table is held in a
// 2^N_IN-bit register that is written one entry per cycle. Input vectors are
// evaluated through a valid/ready stream that has a registered output. A
// self-test sweep walks every table entry and reports how many entries are 1.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   cfg_we       truth-table write strobe (honoured in IDLE only)
//   cfg_addr     table index to write; MSB corresponds to input A
//   cfg_data     function value stored at cfg_addr
//   in_valid     input vector valid
//   in_vec       input vector {A,B,C,...}, MSB is A
//   in_ready     an input vector can be accepted this cycle
//   out_valid    out_f / out_vec hold a result
//   out_ready    downstream accepts the result
//   out_f        table[in_vec] for the accepted vector
//   out_vec      echo of the evaluated vector
//   sweep_start  one-cycle request for an exhaustive sweep
//   sweep_busy   sweep in progress
//   sweep_done   one-cycle pulse when a sweep completes
//   minterm_cnt  number of table entries equal to 1 at the last sweep
// -----------------------------------------------------------------------------
module lut_func_engine #(
  parameter int N_IN = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [N_IN-1:0] cfg_addr,
  input  logic            cfg_data,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_vec,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_f,
  output logic [N_IN-1:0] out_vec,
  input  logic            sweep_start,
  output logic            sweep_busy,
  output logic            sweep_done,
  output logic [N_IN:0]   minterm_cnt
);

  localparam int DEPTH = 2 ** N_IN;
  localparam int IW    = N_IN + 1;

  // The sweep index carries one extra bit so the terminal compare can never
  // alias with a wrapped index.
  localparam logic [IW-1:0] IDX_LAST = IW'(DEPTH - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DEPTH-1:0] lut_q, lut_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic             out_f_q, out_f_d;
  logic [N_IN-1:0]  out_vec_q, out_vec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IW-1:0]    cnt_q, cnt_d;

  logic             in_ready_s;
  logic             eval_fire_s;
  logic             sweep_bit_s;
  logic [IW-1:0]    acc_sum_s;

  // Accept a new vector only in IDLE and only if the output slot is free or
  // is being drained this cycle.
  assign in_ready_s  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign eval_fire_s = in_valid && in_ready_s;

  // Table entry currently addressed by the sweep and the running sum that
  // includes it; the last SWEEP cycle commits this sum directly.
  assign sweep_bit_s = lut_q[idx_q[N_IN-1:0]];
  assign acc_sum_s   = acc_q + {{N_IN{1'b0}}, sweep_bit_s};

  // Next-state logic for the FSM, the table, the eval pipeline and the sweep.
  always_comb begin
    state_d     = state_q;
    lut_d       = lut_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_f_d     = out_f_q;
    out_vec_d   = out_vec_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;

    // Evaluation reads the registered table, so a write landing on the same
    // edge is not visible to this vector.
    if (eval_fire_s) begin
      out_valid_d = 1'b1;
      out_f_d     = lut_q[in_vec];
      out_vec_d   = in_vec;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    // Table writes are only honoured in IDLE; a write coinciding with
    // sweep_start lands before the first sweep read.
    if ((state_q == ST_IDLE) && cfg_we) begin
      lut_d[cfg_addr] = cfg_data;
    end else begin
      lut_d = lut_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (sweep_start) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SWEEP: begin
        acc_d = acc_sum_s;
        idx_d = idx_q + IDX_ONE;
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
          cnt_d   = acc_sum_s;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_SWEEP;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      lut_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_f_q     <= 1'b0;
      out_vec_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      lut_q       <= lut_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_f_q     <= out_f_d;
      out_vec_q   <= out_vec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_q;
  assign out_f       = out_f_q;
  assign out_vec     = out_vec_q;
  assign sweep_busy  = busy_q;
  assign sweep_done  = done_q;
  assign minterm_cnt = cnt_q;

endmodule

// File: tb/tb_lut_func_engine.sv
// -----------------------------------------------------------------------------
// tb_lut_func_engine
//
// Directed bench for lut_func_engine with N_IN = 4: a table of eval vectors
// with hand-computed results for F = A&B | C&D (16'hF888), plus hand-written
// sequences for backpressure, sweeps, writes/evals during a sweep and a reset
// in the middle of a sweep.
// -----------------------------------------------------------------------------
module tb_lut_func_engine;

  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic       cfg_data;
  logic       in_valid;
  logic [3:0] in_vec;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic       out_f;
  logic [3:0] out_vec;
  logic       sweep_start;
  logic       sweep_busy;
  logic       sweep_done;
  logic [4:0] minterm_cnt;

  lut_func_engine #(.N_IN(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .in_valid   (in_valid),
    .in_vec     (in_vec),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_f      (out_f),
    .out_vec    (out_vec),
    .sweep_start(sweep_start),
    .sweep_busy (sweep_busy),
    .sweep_done (sweep_done),
    .minterm_cnt(minterm_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] vec;
    logic       f;
  } vec_t;

  vec_t vt [6];
  int   total;
  int   bad;
  int   dn;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_table(input logic [15:0] t);
    for (int i = 0; i < 16; i++) begin
      cfg_we   = 1'b1;
      cfg_addr = 4'(i);
      cfg_data = t[i];
      step();
    end
    cfg_we = 1'b0;
  endtask

  // Pulse sweep_start and follow the sweep edge by edge. The edge that
  // samples sweep_start is edge 1; busy must be seen after edges 1..16 and
  // done after edge 17 only. With disturb set, a write and an eval request
  // are driven from inside the sweep and must both be ignored.
  task automatic run_sweep(input logic [4:0] exp_cnt, input bit disturb);
    int n;
    int busy_n;
    int done_at;
    int rdy_seen;
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    n        = 1;
    busy_n   = 0;
    done_at  = 0;
    rdy_seen = 0;
    while (done_at == 0 && n < 40) begin
      if (disturb && n == 3) begin
        cfg_we   = 1'b1;
        cfg_addr = 4'd0;
        cfg_data = 1'b1;
        in_valid = 1'b1;
        in_vec   = 4'b1111;
      end
      #1;
      if (sweep_busy) busy_n++;
      if (sweep_done) done_at = n;
      if (in_ready) rdy_seen++;
      step();
      n++;
    end
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    chk("sweep_busy_cycles", 32'(busy_n), 32'd16);
    chk("sweep_done_edge", 32'(done_at), 32'd17);
    chk("sweep_in_ready_low", 32'(rdy_seen), 32'd0);
    chk("sweep_done_one_pulse", 32'(sweep_done), 32'd0);
    chk("sweep_minterm_cnt", 32'(minterm_cnt), 32'(exp_cnt));
    chk("sweep_no_eval_taken", 32'(out_valid), 32'd0);
    #1;
    chk("sweep_back_to_idle", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{4'b0000, 1'b0};
    vt[1] = '{4'b0101, 1'b0};
    vt[2] = '{4'b1100, 1'b1};
    vt[3] = '{4'b1111, 1'b1};
    vt[4] = '{4'b0011, 1'b1};
    vt[5] = '{4'b1010, 1'b0};
    total       = 0;
    bad         = 0;
    dn          = 0;
    clk         = 1'b0;
    rst_n       = 1'b0;
    cfg_we      = 1'b0;
    cfg_addr    = 4'd0;
    cfg_data    = 1'b0;
    in_valid    = 1'b0;
    in_vec      = 4'd0;
    out_ready   = 1'b1;
    sweep_start = 1'b0;

    // Reset state
    repeat (2) step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_f", 32'(out_f), 32'd0);
    chk("rst_out_vec", 32'(out_vec), 32'd0);
    chk("rst_sweep_busy", 32'(sweep_busy), 32'd0);
    chk("rst_sweep_done", 32'(sweep_done), 32'd0);
    chk("rst_minterm_cnt", 32'(minterm_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Empty table evaluates to 0
    in_valid = 1'b1;
    in_vec   = 4'b1011;
    step();
    in_valid = 1'b0;
    chk("empty_out_valid", 32'(out_valid), 32'd1);
    chk("empty_out_f", 32'(out_f), 32'd0);

    load_table(16'hF888);

    // Back-to-back stream with out_ready held high
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_vec   = vt[i].vec;
      #1;
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      step();
      chk("stream_out_valid", 32'(out_valid), 32'd1);
      chk("stream_out_f", 32'(out_f), 32'(vt[i].f));
      chk("stream_out_vec", 32'(out_vec), 32'(vt[i].vec));
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain", 32'(out_valid), 32'd0);

    // Backpressure: first result held for 3 cycles, nothing lost
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_vec    = 4'b1100;
    step();
    in_vec = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_f", 32'(out_f), 32'd1);
      chk("bp_out_vec", 32'(out_vec), 32'(4'b1100));
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    chk("bp_second_valid", 32'(out_valid), 32'd1);
    chk("bp_second_f", 32'(out_f), 32'd0);
    chk("bp_second_vec", 32'(out_vec), 32'(4'b0101));
    in_vec = 4'b1111;
    step();
    in_valid = 1'b0;
    chk("bp_third_f", 32'(out_f), 32'd1);
    chk("bp_third_vec", 32'(out_vec), 32'(4'b1111));
    step();
    chk("bp_drain", 32'(out_valid), 32'd0);

    // Eval in the same cycle as a write to the same entry sees the old value
    cfg_we   = 1'b1;
    cfg_addr = 4'd0;
    cfg_data = 1'b1;
    in_valid = 1'b1;
    in_vec   = 4'b0000;
    step();
    cfg_we = 1'b0;
    chk("wr_eval_old_value", 32'(out_f), 32'd0);
    step();
    chk("wr_eval_new_value", 32'(out_f), 32'd1);
    in_valid = 1'b0;
    cfg_we   = 1'b1;
    cfg_data = 1'b0;
    step();
    cfg_we = 1'b0;
    step();

    // Sweeps on F888, with a disturbed sweep in between
    run_sweep(5'd7, 1'b0);
    run_sweep(5'd7, 1'b1);
    run_sweep(5'd7, 1'b0);

    // Eval accepted with sweep_start, result held through the sweep, then
    // asynchronous reset at sweep cycle 8
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    in_vec      = 4'b1111;
    sweep_start = 1'b1;
    step();
    in_valid    = 1'b0;
    sweep_start = 1'b0;
    chk("ms_eval_valid", 32'(out_valid), 32'd1);
    chk("ms_eval_f", 32'(out_f), 32'd1);
    chk("ms_busy", 32'(sweep_busy), 32'd1);
    repeat (7) step();
    chk("ms_held_valid", 32'(out_valid), 32'd1);
    chk("ms_held_vec", 32'(out_vec), 32'(4'b1111));
    chk("ms_busy_cycle8", 32'(sweep_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ms_rst_out_valid", 32'(out_valid), 32'd0);
    chk("ms_rst_out_f", 32'(out_f), 32'd0);
    chk("ms_rst_out_vec", 32'(out_vec), 32'd0);
    chk("ms_rst_busy", 32'(sweep_busy), 32'd0);
    chk("ms_rst_done", 32'(sweep_done), 32'd0);
    chk("ms_rst_minterm", 32'(minterm_cnt), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ms_rel_in_ready", 32'(in_ready), 32'd1);
    repeat (20) begin
      step();
      if (sweep_done) dn++;
    end
    chk("ms_no_done", 32'(dn), 32'd0);
    chk("ms_idle_busy", 32'(sweep_busy), 32'd0);
    chk("ms_cnt_hold", 32'(minterm_cnt), 32'd0);

    // Fresh sweep on the cleared (all-zeros) table, then all-ones table
    run_sweep(5'd0, 1'b0);
    in_valid = 1'b1;
    in_vec   = 4'b1011;
    step();
    in_valid = 1'b0;
    chk("cleared_out_f", 32'(out_f), 32'd0);
    load_table(16'hFFFF);
    run_sweep(5'd16, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
